// File: rtl/lfsr_range_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_range_gen_if
// Brief   : Control and draw port bundle for lfsr_range_gen.
// Revision: 1.0 - initial release
// ============================================================================
interface lfsr_range_gen_if #(
    parameter int WIDTH = 21,
    parameter int OUT_W = 7
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic [OUT_W-1:0] out;
    logic             valid;
    logic             folded;

    // Master is the consumer driving requests; slave is the generator.
    modport master (
        output en, seed_load, seed_in, req,
        input  busy, out, valid, folded
    );

    modport slave (
        input  en, seed_load, seed_in, req,
        output busy, out, valid, folded
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_range_gen.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_range_gen
// Brief   : Fibonacci LFSR with bounded draws in [RANGE_MIN, RANGE_MAX] by
//           rejection sampling, falling back to a single fold after MAX_TRY.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr_range_gen #(
    parameter int               WIDTH     = 21,
    parameter int               TAP_A     = 20,
    parameter int               TAP_B     = 17,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
    parameter int               OUT_W     = 7,
    parameter int               RANGE_MIN = 0,
    parameter int               RANGE_MAX = 99,
    parameter int               MAX_TRY   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lfsr_range_gen_if.slave    bus
);

    localparam int c_span_int = RANGE_MAX - RANGE_MIN + 1;
    localparam int c_try_w    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

    localparam logic [OUT_W:0]     c_span_ext = (OUT_W+1)'(c_span_int);
    localparam logic [OUT_W-1:0]   c_span     = OUT_W'(c_span_int);
    localparam logic [OUT_W-1:0]   c_min      = OUT_W'(RANGE_MIN);
    localparam logic [c_try_w-1:0] c_last_try = c_try_w'(MAX_TRY - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (!((c_span_int > (1 << (OUT_W - 1))) && (c_span_int <= (1 << OUT_W)) &&
          (RANGE_MAX < (1 << OUT_W)) && (RANGE_MIN >= 0))) begin : g_bad_range
        $error("lfsr_range_gen: RANGE_MIN/RANGE_MAX illegal for OUT_W");
    end

    if ((TAP_A >= WIDTH) || (TAP_B >= WIDTH) || (TAP_A < 0) || (TAP_B < 0) ||
        (TAP_A == TAP_B)) begin : g_bad_taps
        $error("lfsr_range_gen: feedback taps out of range");
    end

    if ((OUT_W > WIDTH) || (OUT_W < 1) || (MAX_TRY < 1)) begin : g_bad_sizes
        $error("lfsr_range_gen: OUT_W or MAX_TRY illegal");
    end

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_range_gen: SEED must be non-zero");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic [WIDTH-1:0]   w_lfsr_step;
    logic [c_try_w-1:0] r_try;
    logic [c_try_w-1:0] w_try_nxt;
    logic [OUT_W-1:0]   r_out;
    logic               r_valid;
    logic               r_folded;

    logic [OUT_W-1:0]   w_cand;
    logic               w_accept;
    logic [OUT_W-1:0]   w_acc_val;
    logic [OUT_W-1:0]   w_fold_val;
    logic               w_step_draw;
    logic               w_done;
    logic               w_fold;
    logic [OUT_W-1:0]   w_result;

    assign w_lfsr_step = {r_lfsr[WIDTH-2:0], r_lfsr[TAP_A] ^ r_lfsr[TAP_B]};

    assign w_cand    = r_lfsr[OUT_W-1:0];
    assign w_accept  = ({1'b0, w_cand} < c_span_ext);
    // Modulo-2^OUT_W arithmetic equals the truncated OUT_W+1-bit result, and
    // both values are already known to lie inside the output range.
    assign w_acc_val  = w_cand + c_min;
    assign w_fold_val = w_cand - c_span + c_min;

    // ------------------------------------------------------------------------
    // Next-state / draw decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_try_nxt   = r_try;
        w_step_draw = 1'b0;
        w_done      = 1'b0;
        w_fold      = 1'b0;
        w_result    = r_out;

        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = S_DRAW;
                    w_try_nxt   = '0;
                end
            end
            S_DRAW: begin
                if (w_accept) begin
                    w_done      = 1'b1;
                    w_result    = w_acc_val;
                    w_state_nxt = S_IDLE;
                end else if (r_try == c_last_try) begin
                    w_done      = 1'b1;
                    w_fold      = 1'b1;
                    w_result    = w_fold_val;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step_draw = 1'b1;
                    w_try_nxt   = r_try + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Seed load wins over any step; an all-zero seed would lock the LFSR.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (bus.seed_load) begin
            w_lfsr_nxt = (bus.seed_in == '0) ? SEED : bus.seed_in;
        end else if (w_step_draw || ((r_state == S_IDLE) && bus.en)) begin
            w_lfsr_nxt = w_lfsr_step;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= SEED;
            r_try    <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_folded <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_try    <= w_try_nxt;
            r_valid  <= w_done;
            r_folded <= w_fold;
            if (w_done) begin
                r_out <= w_result;
            end
        end
    end

    assign bus.busy   = (r_state == S_DRAW);
    assign bus.out    = r_out;
    assign bus.valid  = r_valid;
    assign bus.folded = r_folded;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_lfsr_range_gen
// Brief   : Scoreboard bench for two lfsr_range_gen instances (MAX_TRY 8, 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_lfsr_range_gen;

    localparam int WIDTH = 21;
    localparam int OUT_W = 7;
    localparam int RMIN  = 0;
    localparam int RMAX  = 99;
    localparam int SPAN  = RMAX - RMIN + 1;
    localparam int MT0   = 8;
    localparam int MT1   = 4;
    localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed_in = '0;
    logic             req = 1'b0;

    always #5 clk = ~clk;

    lfsr_range_gen_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus0 ();
    lfsr_range_gen_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus1 ();

    assign bus0.en = en;  assign bus0.seed_load = seed_load;
    assign bus0.seed_in = seed_in;  assign bus0.req = req;
    assign bus1.en = en;  assign bus1.seed_load = seed_load;
    assign bus1.seed_in = seed_in;  assign bus1.req = req;

    lfsr_range_gen #(.MAX_TRY(MT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lfsr_range_gen #(.MAX_TRY(MT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: draws behave as "examine successive LFSR windows until
    // one fits the span, or fold the last one allowed".
    // ------------------------------------------------------------------------
    typedef struct { int out; bit folded; } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    logic [WIDTH-1:0] m_lfsr [2];
    bit               m_draw [2];
    int               m_try  [2];
    bit               m_vexp [2];
    int               cyc = 0;
    int               n_valid [2];
    int               last_vcyc [2];

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[20] ^ s[17]};
    endfunction

    always @(posedge clk) begin
        int mt;
        int c;
        logic [WIDTH-1:0] nxt;
        exp_t e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            mt = (k == 0) ? MT0 : MT1;
            m_vexp[k] = 1'b0;
            if (rst) begin
                m_lfsr[k] = ALL1;
                m_draw[k] = 1'b0;
                m_try[k]  = 0;
            end else begin
                nxt = m_lfsr[k];
                if (m_draw[k]) begin
                    c = int'(m_lfsr[k] % (1 << OUT_W));
                    if (c < SPAN || m_try[k] == mt - 1) begin
                        e.out    = (c < SPAN) ? c + RMIN : c - SPAN + RMIN;
                        e.folded = (c >= SPAN);
                        if (k == 0) q0.push_back(e); else q1.push_back(e);
                        m_vexp[k] = 1'b1;
                        m_draw[k] = 1'b0;
                    end else begin
                        nxt = lfsr_next(nxt);
                        m_try[k]++;
                    end
                end else begin
                    if (en) nxt = lfsr_next(nxt);
                    if (req) begin
                        m_draw[k] = 1'b1;
                        m_try[k]  = 0;
                    end
                end
                if (seed_load) nxt = (seed_in == '0) ? ALL1 : seed_in;
                m_lfsr[k] = nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic mon(input int k, input logic v, input logic b,
                       input logic [OUT_W-1:0] o, input logic f);
        exp_t e;
        chk($sformatf("busy%0d", k), longint'(b), longint'(m_draw[k]));
        chk($sformatf("valid%0d", k), longint'(v), longint'(m_vexp[k]));
        chk($sformatf("busy_and_valid%0d", k), longint'(b & v), 0);
        if (v === 1'b1) begin
            n_valid[k]++;
            last_vcyc[k] = cyc;
            chk($sformatf("range%0d", k), longint'(o >= RMIN && o <= RMAX), 1);
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_valid%0d", k), 1, 0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("out%0d", k), longint'(o), e.out);
                chk($sformatf("folded%0d", k), longint'(f), longint'(e.folded));
            end
        end else begin
            chk($sformatf("folded_idle%0d", k), longint'(f), 0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon(0, bus0.valid, bus0.busy, bus0.out, bus0.folded);
            mon(1, bus1.valid, bus1.busy, bus1.out, bus1.folded);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int rc;
        int v0, v1;
        int guard;
        n_valid[0] = 0; n_valid[1] = 0;
        last_vcyc[0] = 0; last_vcyc[1] = 0;

        // Reset values
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out", longint'(bus0.out), 0);
        chk("rst_valid", longint'(bus0.valid), 0);
        chk("rst_folded", longint'(bus0.folded), 0);
        chk("rst_busy", longint'(bus0.busy), 0);
        chk("rst_lfsr", longint'(dut0.r_lfsr), longint'(ALL1));
        #1;

        // Longest accept path (dut0) and fold path (dut1); extra req while busy
        v0 = n_valid[0]; v1 = n_valid[1];
        rc = cyc;
        req = 1'b1; tick(1); req = 1'b0;
        tick(2);
        req = 1'b1; tick(1); req = 1'b0;
        tick(8);
        chk("seq_out0", longint'(bus0.out), 96);
        chk("seq_out1", longint'(bus1.out), 20);
        chk("lat0", longint'(last_vcyc[0] - rc), 7);
        chk("lat1", longint'(last_vcyc[1] - rc), 5);
        chk("one_valid0", longint'(n_valid[0] - v0), 1);
        chk("one_valid1", longint'(n_valid[1] - v1), 1);

        // Seed load: zero is replaced, small seed accepted at once
        do_reset();
        en = 1'b1; tick(2); en = 1'b0;
        seed_load = 1'b1; seed_in = '0; tick(1); seed_load = 1'b0;
        chk("seed_zero", longint'(dut0.r_lfsr), longint'(ALL1));
        seed_load = 1'b1; seed_in = 21'h000005; tick(1); seed_load = 1'b0;
        chk("seed_five", longint'(dut0.r_lfsr), 5);
        rc = cyc;
        req = 1'b1; tick(1); req = 1'b0;
        tick(3);
        chk("seed_out0", longint'(bus0.out), 5);
        chk("seed_out1", longint'(bus1.out), 5);
        chk("seed_lat", longint'(last_vcyc[0] - rc), 2);

        // Enable behaviour in IDLE
        do_reset();
        tick(10);
        chk("en_hold", longint'(dut0.r_lfsr), longint'(ALL1));
        do_reset();
        en = 1'b1; tick(3); en = 1'b0;
        chk("en_step3", longint'(dut0.r_lfsr), longint'(21'h1FFFF8));

        // Reset mid-draw
        do_reset();
        v0 = n_valid[0]; v1 = n_valid[1];
        req = 1'b1; tick(1); req = 1'b0;
        tick(3);
        rst = 1'b1; tick(1);
        @(negedge clk);
        chk("abort_busy", longint'(bus0.busy), 0);
        chk("abort_out", longint'(bus0.out), 0);
        chk("abort_valid", longint'(bus0.valid), 0);
        #1;
        rst = 1'b0;
        tick(10);
        chk("abort_novalid0", longint'(n_valid[0] - v0), 0);
        chk("abort_novalid1", longint'(n_valid[1] - v1), 0);

        // Randomised back-to-back draws with random enable and reseeding
        do_reset();
        v0 = n_valid[0];
        guard = 0;
        req = 1'b1;
        while ((n_valid[0] - v0) < 1000 && guard < 30000) begin
            en        = 1'($urandom_range(0, 1));
            seed_load = ($urandom_range(0, 15) == 0);
            seed_in   = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            tick(1);
            guard++;
        end
        req = 1'b0; en = 1'b0; seed_load = 1'b0;
        chk("draw_budget", longint'(n_valid[0] - v0 >= 1000), 1);
        tick(12);
        chk("q0_empty", longint'(q0.size()), 0);
        chk("q1_empty", longint'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_range_gen.md
Name: lfsr_range_gen

Overview:
- Parametrised Fibonacci LFSR random source with seed load, enable and a request/valid draw port.
- Each draw returns a value inside [RANGE_MIN, RANGE_MAX], using rejection sampling with a bounded retry count and then a fold.
- Feeds game logic that needs bounded random values, for example obstacle gap height and spawn offset, instead of raw low LFSR bits.

Parameters:
- WIDTH, 21, LFSR register width.
- TAP_A, 20, first feedback tap index.
- TAP_B, 17, second feedback tap index.
- SEED, all ones (WIDTH bits), value after reset; replaces any all-zero seed.
- OUT_W, 7, output width.
- RANGE_MIN, 0, lowest legal output.
- RANGE_MAX, 99, highest legal output.
- MAX_TRY, 8, candidates examined before the fold is forced.
- Legality: SPAN = RANGE_MAX-RANGE_MIN+1 must satisfy 2^(OUT_W-1) < SPAN <= 2^OUT_W, and RANGE_MAX < 2^OUT_W. Assert at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  advance the LFSR one step per cycle while in IDLE.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  draw request, sampled in IDLE only.
- busy  out  1  high while in DRAW.
- out  out  OUT_W  last drawn value, registered, held until the next draw completes.
- valid  out  1  one-cycle pulse when out updates.
- folded  out  1  set with valid when the fold path produced out.

Behaviour:
- One clock; reset is synchronous and active-high, on clk and rst.
- Reset has highest priority. Reset values: state=SEED, out=0, valid=0, folded=0, busy=0, FSM=IDLE, try counter=0. Reset mid-DRAW aborts the draw with no valid pulse.
- Step: next = {state[WIDTH-2:0], state[TAP_A]^state[TAP_B]}.
- LFSR update priority after reset:
  - seed_load: state=seed_in, or SEED if seed_in==0.
  - else DRAW with reject: step.
  - else IDLE with en=1: step.
  - else hold.
- seed_load during DRAW replaces the state; the draw continues from the new state next cycle.
- Candidate c = state[OUT_W-1:0], evaluated combinationally in DRAW.
- FSM IDLE:
  - req=1 → DRAW; try=0; busy=1 next cycle.
  - No candidate is evaluated in the req cycle, but en may still step the LFSR.
- FSM DRAW, each cycle:
  - Accept if c < SPAN: out=c+RANGE_MIN, folded=0, valid=1 next cycle, → IDLE.
  - Else if try==MAX_TRY-1: fold, out=c-SPAN+RANGE_MIN, folded=1, valid=1, → IDLE. The legality rule guarantees the fold result is in range.
  - Else reject: step the LFSR, try+1, stay in DRAW.
- req while busy is ignored; there is no queue.
- On accept or fold cycles the LFSR does not step for the draw. en is ignored in DRAW.
- Latency: valid rises k+1 edges after the req edge, where k = 1..MAX_TRY is the candidate index used. Minimum is 2 cycles; maximum is MAX_TRY+1 cycles.
- valid and folded drop the cycle after the pulse; out holds its value.
- Back-to-back: req held high in the IDLE cycle right after a valid pulse starts the next draw. This gives one IDLE cycle between draws.
- Arithmetic: c-SPAN and c+RANGE_MIN are computed at OUT_W+1 bits and truncated to OUT_W bits. Both results are proven in range, so truncation never loses information.
- The all-zero state is unreachable via seed; no runtime lockup check is needed.

Test Plan:
- Reset then req=1 for one cycle, en=0, default parameters → candidates 127,126,124,120,112,96. busy high for 6 cycles; valid pulses with out=96, folded=0, 7 edges after req.
- Same stimulus with MAX_TRY=4 → 4th candidate 120 folds to out=20, folded=1, valid 5 edges after req.
- Assert seed_load with seed_in=0 → state becomes 0x1FFFFF. seed_load with seed_in=0x000005, then req → c=5 accepted on the first candidate, out=5, valid 2 edges after req.
- en=0 for 10 cycles in IDLE → state unchanged. en=1 for 3 cycles from reset → state 0x1FFFF8.
- Pulse req again while busy=1 → ignored, exactly one valid. Assert rst mid-DRAW → no valid, all outputs at reset values, FSM in IDLE.
- Hold req high for 1000 draws with random seed_load → every out within [0,99], valid always one cycle wide, busy never high together with valid.
